pkt_scheduler: RTL and testbench

PKT_SCHEDULER -- requirements
Module: pkt_scheduler

---
 rtl/pkt_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pkt_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_scheduler.sv
// pkt_scheduler: four-port round-robin packet scheduler.
// Serves one queued packet at a time (address, length N, N payload bytes,
// parity byte) from the granted first-word-fall-through queue onto a single
// valid/ready byte stream. A granted port keeps the output until its parity
// byte has gone, even when its queue runs dry mid-packet.
// Optional build macro: PKT_SCHED_PARITY_CHECK_EN enables the XOR parity
// checker and the parity_err pulse; without it parity_err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet in flight; picks next non-empty port round-robin
// ADDR    | sending the address byte (sop)
// LEN     | sending the length byte; loads the payload counter with N
// PAYLOAD | sending payload bytes; counter counts down to 1
// PARITY  | sending the parity byte (eop); records last_grant
// GAP     | IDLE_GAP cycles of enforced silence after a packet
module pkt_scheduler #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fifo_empty,
    input  logic [31:0] fifo_data,
    output logic [3:0]  fifo_rd_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    // GAP counts down to zero, so it starts one below the gap length.
    localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant_nxt;
    logic [1:0] last_grant;
    logic [1:0] last_grant_nxt;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [3:0] gap_cnt;
    logic [3:0] gap_cnt_nxt;

    logic       in_pkt;
    logic       xfer;
    logic [7:0] lane;
    logic [1:0] rr_pick;
    logic       rr_found;
    logic [1:0] rr_idx;

    // Head byte of the granted queue.
    assign lane = fifo_data[{grant, 3'b000} +: 8];

    // Round-robin search starting one past the last port that finished a packet.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        rr_idx   = last_grant;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant + 2'(i);
            if (!rr_found && !fifo_empty[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // State, grant, counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            count      <= 8'd0;
            gap_cnt    <= 4'd0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            count      <= count_nxt;
            gap_cnt    <= gap_cnt_nxt;
        end
    end

    // Next-state decode and stream outputs; out_valid never looks at out_ready.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        count_nxt      = count;
        gap_cnt_nxt    = gap_cnt;

        in_pkt     = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_PARITY);
        out_valid  = in_pkt && !fifo_empty[grant];
        xfer       = out_valid && out_ready;
        out_data   = out_valid ? lane : 8'h00;
        fifo_rd_en = xfer ? (4'b0001 << grant) : 4'b0000;
        out_sop    = out_valid && (state == S_ADDR);
        out_eop    = out_valid && (state == S_PARITY);
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_pick;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    count_nxt = lane;
                    state_nxt = (lane == 8'd0) ? S_PARITY : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    count_nxt = count - 8'd1;
                    if (count == 8'd1) state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                if (xfer) begin
                    last_grant_nxt = grant;
                    if (IDLE_GAP > 0) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_nxt = S_IDLE;
                else                 gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef PKT_SCHED_PARITY_CHECK_EN
    logic [7:0] par_acc;

    // XOR of address, length and payload; cleared while idle so each packet starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_acc    <= 8'h00;
            parity_err <= 1'b0;
        end else begin
            parity_err <= xfer && (state == S_PARITY) && (lane != par_acc);
            if (state == S_IDLE)
                par_acc <= 8'h00;
            else if (xfer && (state != S_PARITY))
                par_acc <= par_acc ^ lane;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_scheduler.sv
// Bench for pkt_scheduler: queue-level reference model with directed
// scenarios followed by randomized packets, random trickle fill and
// random backpressure.
`timescale 1ns/1ps
module tb_pkt_scheduler;

    localparam int GAP = 3;
`ifdef PKT_SCHED_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  grant;
    logic        busy;
    logic        parity_err;

    pkt_scheduler #(.IDLE_GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .grant      (grant),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Upstream queues: vq is what the DUT sees, bk is not yet delivered.
    logic [7:0] vq[4][$];
    logic [7:0] bk[4][$];
    int  feed_mode = 0;   // 0 none, 1 random trickle, 2 deliver everything
    bit  rdy_rand  = 1'b0;

    typedef struct {
        int         port;
        logic [7:0] b;
        bit         sop;
        bit         eop;
        int         cyc;
    } xfer_t;
    xfer_t lg[$];
    int    cyc      = 0;
    int    perr_cnt = 0;

    // Reference model: which packet is in flight and where we are inside it.
    bit         m_idle = 1'b1;
    bit         m_act  = 1'b0;
    int         m_port = 0;
    int         m_last = 3;
    int         m_pos  = 0;
    int         m_len  = 0;
    int         m_gap  = 0;
    logic [7:0] m_acc  = 8'h00;
    bit         m_perr = 1'b0;

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            fifo_empty[p]       = (vq[p].size() == 0);
            fifo_data[8*p +: 8] = (vq[p].size() != 0) ? vq[p][0] : 8'h00;
        end
    endtask

    function automatic bit queues_empty();
        bit e = 1'b1;
        for (int p = 0; p < 4; p++)
            if (vq[p].size() != 0 || bk[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_idle = 1'b1; m_act = 1'b0; m_port = 0; m_last = 3;
        m_pos = 0; m_len = 0; m_gap = 0; m_acc = 8'h00; m_perr = 1'b0;
    endtask

    // One clock: check at negedge, advance model, pop/refill after posedge.
    task automatic step();
        logic       exp_v;
        logic [7:0] exp_d;
        logic [7:0] b;
        bit         tr;
        bit         found;
        int         pick;
        logic [3:0] rd_s;
        xfer_t      x;
        @(negedge clk);
        cyc++;
        exp_v = m_act && (vq[m_port].size() != 0);
        exp_d = exp_v ? vq[m_port][0] : 8'h00;
        tr    = exp_v && out_ready;
        chk("valid", out_valid, exp_v);
        chk("data", out_data, exp_d);
        chk("sop", out_sop, exp_v && m_pos == 0);
        chk("eop", out_eop, exp_v && m_pos >= 2 && m_pos == m_len - 1);
        chk("rd_en", fifo_rd_en, tr ? (32'd1 << m_port) : 32'd0);
        chk("grant", grant, m_port);
        chk("busy", busy, !m_idle);
        chk("perr", parity_err, m_perr);
        if (parity_err) perr_cnt++;
        if (out_valid && out_ready) begin
            x.port = int'(grant); x.b = out_data; x.sop = out_sop; x.eop = out_eop; x.cyc = cyc;
            lg.push_back(x);
        end
        rd_s = fifo_rd_en;

        m_perr = 1'b0;
        if (m_idle) begin
            found = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                pick = (m_last + i) % 4;
                if (!found && vq[pick].size() != 0) begin
                    found = 1'b1; m_port = pick; m_act = 1'b1; m_idle = 1'b0;
                    m_pos = 0; m_len = 0;
                end
            end
        end else if (m_act) begin
            if (tr) begin
                b = vq[m_port][0];
                if (m_pos == 1) m_len = int'(b) + 3;
                if (m_pos >= 2 && m_pos == m_len - 1) begin
                    m_perr = PAR_ON && (b != m_acc);
                    m_last = m_port;
                    m_act  = 1'b0;
                    if (GAP > 0) m_gap = GAP; else m_idle = 1'b1;
                end else begin
                    m_acc = (m_pos == 0) ? b : (m_acc ^ b);
                end
                m_pos++;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_idle = 1'b1;
        end

        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++)
            if (rd_s[p] && vq[p].size() != 0) void'(vq[p].pop_front());
        for (int p = 0; p < 4; p++) begin
            if (feed_mode == 2) begin
                while (bk[p].size() != 0) vq[p].push_back(bk[p].pop_front());
            end else if (feed_mode == 1) begin
                if (bk[p].size() != 0 && $urandom_range(0, 3) != 0)
                    vq[p].push_back(bk[p].pop_front());
            end
        end
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (!(m_idle && queues_empty()) && n < bound) begin
            step();
            n++;
        end
        chk("run_bound", m_idle && queues_empty(), 1);
    endtask

    task automatic step_until_log(input int want, input int bound);
        int n = 0;
        while (lg.size() < want && n < bound) begin
            step();
            n++;
        end
        chk("log_bound", lg.size() >= want, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin vq[p].delete(); bk[p].delete(); end
        drive();
        model_reset();
        lg.delete();
        perr_cnt  = 0;
        feed_mode = 0;
        rdy_rand  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input int p, input logic [7:0] b);
        vq[p].push_back(b);
    endtask

    initial begin
        logic [7:0] exp1[5];
        logic [7:0] exp3[7];
        logic [7:0] acc;
        logic [7:0] x;
        int         p;
        int         n;
        int         total;

        reset = 1'b1; out_ready = 1'b1; fifo_empty = 4'hF; fifo_data = 32'h0;
        push(1, 8'h77); drive();
        #13;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", parity_err, 0);

        // Single packet on port 1, no backpressure.
        do_reset();
        out_ready = 1'b1;
        exp1 = '{8'h55, 8'h02, 8'hAA, 8'hBB, 8'hEE};
        for (int i = 0; i < 5; i++) push(1, exp1[i]);
        drive();
        run_idle(40);
        chk("t1_count", lg.size(), 5);
        if (lg.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t1_byte", lg[i].b, exp1[i]);
                chk("t1_port", lg[i].port, 1);
            end
            chk("t1_sop", lg[0].sop, 1);
            chk("t1_eop", lg[4].eop, 1);
            chk("t1_back2back", lg[4].cyc - lg[0].cyc, 4);
        end
        // 0x55^0x02^0xAA^0xBB = 0x46, so 0xEE only trips the checker when it is built in.
        chk("t1_perr", perr_cnt, PAR_ON ? 1 : 0);

        // Round robin from reset: 0,1,2,3, then port 0 ahead of port 2.
        do_reset();
        out_ready = 1'b1;
        for (int q = 0; q < 4; q++) begin
            push(q, 8'(8'h10 + q)); push(q, 8'h01); push(q, 8'(8'h20 + q));
            push(q, 8'(8'h10 + q) ^ 8'h01 ^ 8'(8'h20 + q));
        end
        drive();
        run_idle(100);
        n = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i].sop) begin
                if (n < 4) chk("rr_order", lg[i].port, n);
                n++;
            end
        chk("rr_pkts", n, 4);
        lg.delete();
        push(2, 8'h62); push(2, 8'h00); push(2, 8'h62);
        push(0, 8'h60); push(0, 8'h00); push(0, 8'h60);
        drive();
        run_idle(60);
        chk("rr_refill_cnt", lg.size(), 6);
        if (lg.size() == 6) begin
            chk("rr_refill_first", lg[0].port, 0);
            chk("rr_refill_second", lg[3].port, 2);
        end

        // Backpressure: three stalled cycles on the second payload byte.
        do_reset();
        out_ready = 1'b1;
        exp3 = '{8'h10, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h14};
        for (int i = 0; i < 7; i++) push(1, exp3[i]);
        drive();
        step_until_log(3, 20);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'hA2);
            chk("bp_rd_en", fifo_rd_en, 0);
        end
        out_ready = 1'b1;
        run_idle(40);
        chk("bp_count", lg.size(), 7);
        if (lg.size() == 7)
            for (int i = 0; i < 7; i++) chk("bp_seq", lg[i].b, exp3[i]);

        // Zero-length packet on port 2 whose parity byte arrives late.
        do_reset();
        out_ready = 1'b1;
        push(2, 8'h30); push(2, 8'h00);
        drive();
        repeat (6) step();
        chk("ur_valid", out_valid, 0);
        chk("ur_grant", grant, 2);
        chk("ur_busy", busy, 1);
        chk("ur_count", lg.size(), 2);
        push(2, 8'h30);
        drive();
        run_idle(30);
        chk("ur_total", lg.size(), 3);
        if (lg.size() == 3) begin
            chk("ur_eop", lg[2].eop, 1);
            chk("ur_par", lg[2].b, 8'h30);
            chk("ur_port", lg[2].port, 2);
        end

        // Bad parity, then gap before the next packet.
        do_reset();
        out_ready = 1'b1;
        push(0, 8'h11); push(0, 8'h01); push(0, 8'h22); push(0, 8'h00);
        push(1, 8'h40); push(1, 8'h00); push(1, 8'h40);
        drive();
        run_idle(60);
        chk("par_pulses", perr_cnt, PAR_ON ? 1 : 0);
        chk("gap_count", lg.size(), 7);
        if (lg.size() == 7) begin
            chk("gap_eop", lg[3].eop, 1);
            chk("gap_sop", lg[4].sop, 1);
            // GAP silent cycles plus the idle cycle that samples the queue.
            chk("gap_len", lg[4].cyc - lg[3].cyc - 1, GAP + 1);
        end

        // Reset in the middle of a payload; port 0 wins afterwards.
        do_reset();
        out_ready = 1'b1;
        push(1, 8'h50); push(1, 8'h05);
        for (int i = 1; i <= 5; i++) push(1, 8'(i));
        push(1, 8'h00);
        drive();
        step_until_log(4, 20);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rd_en", fifo_rd_en, 0);
        for (int q = 0; q < 4; q++) vq[q].delete();
        model_reset();
        lg.delete();
        push(3, 8'h73); push(3, 8'h00); push(3, 8'h73);
        push(0, 8'h70); push(0, 8'h00); push(0, 8'h70);
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_idle(60);
        chk("mr_count", lg.size(), 6);
        if (lg.size() == 6) chk("mr_first", lg[0].port, 0);

        // Random packets, trickle fill, random backpressure.
        do_reset();
        total = 0;
        for (int k = 0; k < 40; k++) begin
            p = $urandom_range(0, 3);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 5);
            x = 8'($urandom); acc = x; bk[p].push_back(x);
            bk[p].push_back(8'(n)); acc = acc ^ 8'(n);
            for (int j = 0; j < n; j++) begin
                x = 8'($urandom); acc = acc ^ x; bk[p].push_back(x);
            end
            if ($urandom_range(0, 3) == 0) acc = ~acc;
            bk[p].push_back(acc);
            total += n + 3;
        end
        feed_mode = 1;
        rdy_rand  = 1'b1;
        repeat (1500) step();
        feed_mode = 2;
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        run_idle(5000);
        chk("rand_bytes", lg.size(), total);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
